// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU and a 32-iteration shift-add
// multiplier that stalls the front of the pipe, feeding the EX/MEM register.
module ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] RDData0_i,
    input  logic [31:0] RDData1_i,
    input  logic [31:0] SignExtended_i,
    input  logic [4:0]  RSaddr_i,
    input  logic [4:0]  RTaddr_i,
    input  logic [4:0]  RegDst_i,
    input  logic [1:0]  ALUOp_i,
    input  logic        ALUSrc_i,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        wb_RegWrite_i,
    input  logic [4:0]  wb_RegDst_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] ALUResult_o,
    output logic [31:0] WriteData_o,
    output logic [4:0]  RegDst_o,
    output logic        RegWrite_o,
    output logic        MemToReg_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        stall_o
);
    localparam int unsigned DW    = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned CNT_W = 5;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d, product_q, product_d;
    logic [DW-1:0]     alu_result_q, alu_result_d, write_data_q, write_data_d;
    logic [RW-1:0]     reg_dst_q, reg_dst_d;
    logic              reg_write_q, reg_write_d, mem_to_reg_q, mem_to_reg_d;
    logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;

    logic [DW-1:0]     fwd_a_c, fwd_b_c, op_b_c, alu_c, mul_step_c;
    logic              is_mul_c, stall_c;
    logic [5:0]        funct_c;
    logic              unused_inst_c;

    assign funct_c       = inst_i[5:0];
    assign unused_inst_c = ^inst_i[31:6];
    assign is_mul_c      = (ALUOp_i == 2'b10) && (funct_c == FN_MUL);

    // Forwarding: EX/MEM beats MEM/WB; register 0 is never forwarded
    always_comb begin
        fwd_a_c = RDData0_i;
        if (reg_write_q && reg_dst_q != '0 && reg_dst_q == RSaddr_i)
            fwd_a_c = alu_result_q;
        else if (wb_RegWrite_i && wb_RegDst_i != '0 && wb_RegDst_i == RSaddr_i)
            fwd_a_c = wb_data_i;

        fwd_b_c = RDData1_i;
        if (reg_write_q && reg_dst_q != '0 && reg_dst_q == RTaddr_i)
            fwd_b_c = alu_result_q;
        else if (wb_RegWrite_i && wb_RegDst_i != '0 && wb_RegDst_i == RTaddr_i)
            fwd_b_c = wb_data_i;

        op_b_c = ALUSrc_i ? SignExtended_i : fwd_b_c;
    end

    // Single-cycle ALU; multiply goes through the sequential path instead
    always_comb begin
        alu_c = '0;
        case (ALUOp_i)
            2'b00: alu_c = fwd_a_c + op_b_c;
            2'b01: alu_c = fwd_a_c - op_b_c;
            2'b11: alu_c = fwd_a_c | op_b_c;
            default: begin
                case (funct_c)
                    FN_ADD:  alu_c = fwd_a_c + op_b_c;
                    FN_SUB:  alu_c = fwd_a_c - op_b_c;
                    FN_AND:  alu_c = fwd_a_c & op_b_c;
                    FN_OR:   alu_c = fwd_a_c | op_b_c;
                    FN_SLT:  alu_c = ($signed(fwd_a_c) < $signed(op_b_c)) ? DW'(1) : '0;
                    default: alu_c = '0;
                endcase
            end
        endcase
    end

    assign mul_step_c = mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        product_d    = product_q;
        stall_c      = 1'b0;
        alu_result_d = alu_c;
        write_data_d = fwd_b_c;
        reg_dst_d    = RegDst_i;
        reg_write_d  = RegWrite_i;
        mem_to_reg_d = MemToReg_i;
        mem_read_d   = MemRead_i;
        mem_write_d  = MemWrite_i;

        case (state_q)
            IDLE: begin
                if (is_mul_c) begin
                    mul_a_d   = fwd_a_c;
                    mul_b_d   = fwd_b_c;
                    product_d = '0;
                    cnt_d     = '0;
                    stall_c   = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                stall_c   = 1'b1;
                product_d = product_q + mul_step_c;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(31))
                    state_d = DONE;
            end
            DONE: begin
                // The held multiply is retired here, not restarted
                alu_result_d = product_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (stall_c) begin
            alu_result_d = '0;
            write_data_d = '0;
            reg_dst_d    = '0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            product_q    <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            reg_dst_q    <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            product_q    <= product_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            reg_dst_q    <= reg_dst_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign stall_o     = stall_c & ~rst_i;
    assign ALUResult_o = alu_result_q;
    assign WriteData_o = write_data_q;
    assign RegDst_o    = reg_dst_q;
    assign RegWrite_o  = reg_write_q;
    assign MemToReg_o  = mem_to_reg_q;
    assign MemRead_o   = mem_read_q;
    assign MemWrite_o  = mem_write_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding priority, multiply stall/bubble
// timing, and reset abort of a multiply.
module tb_ex_stage;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] inst_i, RDData0_i, RDData1_i, SignExtended_i, wb_data_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RegDst_i, wb_RegDst_i;
    logic [1:0]  ALUOp_i;
    logic        ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, wb_RegWrite_i;
    logic [31:0] ALUResult_o, WriteData_o;
    logic [4:0]  RegDst_o;
    logic        RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, stall_o;

    int checks   = 0;
    int failures = 0;

    ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i),
        .RDData0_i(RDData0_i), .RDData1_i(RDData1_i), .SignExtended_i(SignExtended_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RegDst_i(RegDst_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
        .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .wb_RegWrite_i(wb_RegWrite_i), .wb_RegDst_i(wb_RegDst_i), .wb_data_i(wb_data_i),
        .ALUResult_o(ALUResult_o), .WriteData_o(WriteData_o), .RegDst_o(RegDst_o),
        .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return ALUResult_o | WriteData_o |
               {23'b0, RegDst_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o};
    endfunction

    // Multiply already driven on inputs: expects 33 stalled bubble cycles, then the product
    task automatic do_mul(input string tag, input logic [31:0] exp, input logic [4:0] dst);
        int n;
        #1;
        chk({tag, "_stall_first"}, 32'(stall_o), 32'd1);
        n = 0;
        while (stall_o === 1'b1 && n < 40) begin
            tick();
            n++;
            chk({tag, "_bubble"}, all_outs(), 32'd0);
        end
        chk({tag, "_stall_len"}, 32'(n), 32'd33);
        tick();
        chk({tag, "_result"}, ALUResult_o, exp);
        chk({tag, "_dst"}, {26'b0, RegWrite_o, RegDst_o}, {26'b0, 1'b1, dst});
    endtask

    initial begin
        rst_i = 1'b1; inst_i = '0; RDData0_i = '0; RDData1_i = '0; SignExtended_i = '0;
        RSaddr_i = '0; RTaddr_i = '0; RegDst_i = '0; ALUOp_i = '0; ALUSrc_i = 1'b0;
        RegWrite_i = 1'b0; MemToReg_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        wb_RegWrite_i = 1'b0; wb_RegDst_i = '0; wb_data_i = '0;
        tick(); tick();
        chk("reset_outs", all_outs(), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);

        // Multiply presented during reset must not stall or start
        ALUOp_i = 2'b10; inst_i = 32'h18; RDData0_i = 32'd6; RDData1_i = 32'd7; RegWrite_i = 1'b1;
        #1 chk("rst_mul_stall", 32'(stall_o), 32'd0);
        tick();
        chk("rst_mul_outs", all_outs(), 32'd0);

        // add 5+7
        rst_i = 1'b0; inst_i = 32'h20; RSaddr_i = 5'd1; RTaddr_i = 5'd2;
        RDData0_i = 32'd5; RDData1_i = 32'd7; RegDst_i = 5'd2; RegWrite_i = 1'b1;
        #1 chk("add_nostall", 32'(stall_o), 32'd0);
        tick();
        chk("add_res", ALUResult_o, 32'd12);
        chk("add_ctl", {26'b0, RegWrite_o, RegDst_o}, {26'b0, 1'b1, 5'd2});
        chk("add_wd", WriteData_o, 32'd7);

        // EX/MEM ends up holding r3=9
        RSaddr_i = 5'd10; RTaddr_i = 5'd11; RDData0_i = 32'd4; RDData1_i = 32'd5; RegDst_i = 5'd3;
        tick();
        chk("r3_res", ALUResult_o, 32'd9);

        // EX/MEM (9) wins over WB (4) for rs=r3
        wb_RegWrite_i = 1'b1; wb_RegDst_i = 5'd3; wb_data_i = 32'd4;
        RSaddr_i = 5'd3; RDData0_i = 32'd1; RTaddr_i = 5'd12; RDData1_i = 32'd2;
        RegDst_i = 5'd0; RegWrite_i = 1'b0;
        tick();
        chk("fwd_exmem_prio", ALUOp_i == 2'b10 ? ALUResult_o : 32'hDEAD, 32'd11);

        // WB forwarding with immediate operand
        ALUOp_i = 2'b00; ALUSrc_i = 1'b1; SignExtended_i = 32'd100;
        RTaddr_i = 5'd13; RDData1_i = 32'd55; RegDst_i = 5'd9; RegWrite_i = 1'b1;
        tick();
        chk("fwd_wb_imm", ALUResult_o, 32'd104);
        chk("imm_wd", WriteData_o, 32'd55);

        // sub with immediate; store data forwarded from EX/MEM
        wb_RegWrite_i = 1'b0; ALUOp_i = 2'b01; SignExtended_i = 32'd4;
        RSaddr_i = 5'd9; RDData0_i = 32'd0; RTaddr_i = 5'd9; RDData1_i = 32'd0;
        MemWrite_i = 1'b1; RegWrite_i = 1'b0; RegDst_i = 5'd0;
        tick();
        chk("sub_imm", ALUResult_o, 32'd100);
        chk("store_fwd", WriteData_o, 32'd104);
        chk("memwrite", 32'(MemWrite_o), 32'd1);

        // ALUOp=11 OR, writing r0
        ALUOp_i = 2'b11; ALUSrc_i = 1'b0; MemWrite_i = 1'b0;
        RSaddr_i = 5'd14; RDData0_i = 32'hF0; RTaddr_i = 5'd15; RDData1_i = 32'h0F;
        RegDst_i = 5'd0; RegWrite_i = 1'b1;
        tick();
        chk("op_or", ALUResult_o, 32'hFF);

        // r0 is never forwarded
        ALUOp_i = 2'b10; inst_i = 32'h25; RSaddr_i = 5'd0; RDData0_i = 32'h10;
        RTaddr_i = 5'd0; RDData1_i = 32'h20; RegWrite_i = 1'b0;
        tick();
        chk("r0_nofwd", ALUResult_o, 32'h30);

        inst_i = 32'h24; RSaddr_i = 5'd14; RTaddr_i = 5'd15; RDData0_i = 32'hFF00; RDData1_i = 32'h0FF0;
        tick();
        chk("fn_and", ALUResult_o, 32'h0F00);

        inst_i = 32'h22; RDData0_i = 32'd3; RDData1_i = 32'd5;
        tick();
        chk("fn_sub_wrap", ALUResult_o, 32'hFFFF_FFFE);

        inst_i = 32'h3F; MemRead_i = 1'b1; MemToReg_i = 1'b1;
        tick();
        chk("fn_unknown", ALUResult_o, 32'd0);
        chk("mem_ctl", {30'b0, MemRead_o, MemToReg_o}, 32'd3);

        inst_i = 32'h2A; MemRead_i = 1'b0; MemToReg_i = 1'b0;
        RDData0_i = 32'hFFFF_FFFF; RDData1_i = 32'd1;
        tick();
        chk("slt_neg", ALUResult_o, 32'd1);

        RDData0_i = 32'd1; RDData1_i = 32'hFFFF_FFFF;
        tick();
        chk("slt_pos", ALUResult_o, 32'd0);

        inst_i = 32'h20; RDData0_i = 32'hFFFF_FFFF; RDData1_i = 32'd1; RegDst_i = 5'd6; RegWrite_i = 1'b1;
        tick();
        chk("add_wrap", ALUResult_o, 32'd0);
        chk("add_wrap_dst", 32'(RegDst_o), 32'd6);

        // Multiplies, back to back
        inst_i = 32'h18; RSaddr_i = 5'd20; RTaddr_i = 5'd21;
        RDData0_i = 32'd6; RDData1_i = 32'd7; RegDst_i = 5'd7;
        do_mul("mul6x7", 32'd42, 5'd7);

        RSaddr_i = 5'd22; RTaddr_i = 5'd23; RDData0_i = 32'h0001_0000; RDData1_i = 32'h0003_0000;
        RegDst_i = 5'd8;
        do_mul("mul_hi", 32'd0, 5'd8);

        wb_RegWrite_i = 1'b1; wb_RegDst_i = 5'd5; wb_data_i = 32'hFFFF_FFFF;
        RSaddr_i = 5'd5; RDData0_i = 32'd0; RTaddr_i = 5'd24; RDData1_i = 32'd3; RegDst_i = 5'd9;
        do_mul("mul_fwd", 32'hFFFF_FFFD, 5'd9);
        wb_RegWrite_i = 1'b0;

        // Reset at BUSY counter 10 aborts the multiply
        RSaddr_i = 5'd20; RTaddr_i = 5'd21; RDData0_i = 32'd6; RDData1_i = 32'd7; RegDst_i = 5'd10;
        #1;
        repeat (11) tick();
        chk("busy_stall", 32'(stall_o), 32'd1);
        rst_i = 1'b1;
        #1 chk("rst_busy_stall", 32'(stall_o), 32'd0);
        tick();
        chk("rst_busy_outs", all_outs(), 32'd0);
        rst_i = 1'b0; inst_i = 32'h20; RDData0_i = 32'd3; RDData1_i = 32'd4; RegDst_i = 5'd11;
        #1 chk("post_rst_stall", 32'(stall_o), 32'd0);
        tick();
        chk("post_rst_add", ALUResult_o, 32'd7);
        repeat (3) tick();
        chk("no_late_product", ALUResult_o, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
